// File: rtl/wb_evict_buffer.sv
// Write-back eviction buffer: in-order queue of dirty-line evictions drained to memory,
// with same-cycle lookup forwarding and flush. Optional macro WB_COALESCE_EN enables
// in-place data merge for repeated non-head addresses.
//
// state | meaning
// IDLE  | accepting evictions, draining opportunistically
// FLUSH | evictions blocked, draining until empty, then pulse flush_done
module wb_evict_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_evict_valid,
    input  logic [ADDR_W-1:0]          i_evict_addr,
    input  logic [DATA_W-1:0]          i_evict_data,
    output logic                       o_evict_ready,
    input  logic [ADDR_W-1:0]          i_lookup_addr,
    output logic                       o_lookup_hit,
    output logic [DATA_W-1:0]          o_lookup_data,
    output logic                       o_mem_valid,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [DATA_W-1:0]          o_mem_data,
    input  logic                       i_mem_ready,
    input  logic                       i_flush,
    output logic                       o_flush_done,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t              r_state, w_state_nxt;
    logic                r_flush_done, w_flush_done_nxt;
    logic [ADDR_W-1:0]   r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [PTR_W-1:0]    r_head, r_tail;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic                w_push, w_pop, w_append;
    logic                w_co_hit;
    logic [PTR_W-1:0]    w_co_idx;

    assign o_empty       = (r_count == '0);
    assign o_count       = r_count;
    assign o_evict_ready = (r_count < CNT_W'(DEPTH)) && (r_state == IDLE);
    assign o_mem_valid   = !o_empty;
    assign o_mem_addr    = o_mem_valid ? r_addr[r_head] : '0;
    assign o_mem_data    = o_mem_valid ? r_data[r_head] : '0;
    assign o_flush_done  = r_flush_done;

    assign w_push   = i_evict_valid && o_evict_ready;
    assign w_pop    = o_mem_valid && i_mem_ready;
    assign w_append = w_push && !w_co_hit;

    // Scan oldest to newest so the newest occupied match wins.
    always_comb begin
        o_lookup_hit  = 1'b0;
        o_lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) && (r_addr[r_head + PTR_W'(k)] == i_lookup_addr)) begin
                o_lookup_hit  = 1'b1;
                o_lookup_data = r_data[r_head + PTR_W'(k)];
            end
        end
    end

`ifdef WB_COALESCE_EN
    // Head is skipped: it may be mid-handshake with memory.
    always_comb begin
        w_co_hit = 1'b0;
        w_co_idx = '0;
        for (int k = 1; k < DEPTH; k++) begin
            if ((CNT_W'(k) < r_count) && (r_addr[r_head + PTR_W'(k)] == i_evict_addr)) begin
                w_co_hit = 1'b1;
                w_co_idx = r_head + PTR_W'(k);
            end
        end
    end
`else
    assign w_co_hit = 1'b0;
    assign w_co_idx = '0;
`endif

    always_comb begin
        w_count_nxt = r_count;
        if (w_append && !w_pop)
            w_count_nxt = r_count + CNT_W'(1);
        else if (!w_append && w_pop)
            w_count_nxt = r_count - CNT_W'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_addr[k] <= '0;
                r_data[k] <= '0;
            end
        end else begin
            if (w_push && w_co_hit) begin
                r_data[w_co_idx] <= i_evict_data;
            end else if (w_append) begin
                r_addr[r_tail] <= i_evict_addr;
                r_data[r_tail] <= i_evict_data;
                r_tail         <= r_tail + PTR_W'(1);
            end
            if (w_pop)
                r_head <= r_head + PTR_W'(1);
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flush_done <= w_flush_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_flush)
                    w_state_nxt = FLUSH;
            end
            FLUSH: begin
                if (w_count_nxt == '0) begin
                    w_state_nxt      = IDLE;
                    w_flush_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_evict_buffer.sv
// Self-checking bench for wb_evict_buffer: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the buffer behaviour.
module tb_wb_evict_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic [31:0] ev_addr, ev_data;
    logic        ev_ready;
    logic [31:0] lk_addr;
    logic        lk_hit;
    logic [31:0] lk_data;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_data;
    logic        mem_ready;
    logic        flush;
    logic        flush_done;
    logic [2:0]  count;
    logic        empty;

    wb_evict_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_evict_valid(ev_valid), .i_evict_addr(ev_addr), .i_evict_data(ev_data),
        .o_evict_ready(ev_ready),
        .i_lookup_addr(lk_addr), .o_lookup_hit(lk_hit), .o_lookup_data(lk_data),
        .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
        .i_mem_ready(mem_ready),
        .i_flush(flush), .o_flush_done(flush_done),
        .o_count(count), .o_empty(empty)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: entries oldest-first, flushing flag, expected flush_done.
    logic [31:0] m_a[$];
    logic [31:0] m_d[$];
    bit          m_flushing;
    bit          m_done;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cmp_outputs();
        logic        e_hit;
        logic [31:0] e_ldata;
        int          sz;
        sz      = m_a.size();
        e_hit   = 1'b0;
        e_ldata = 32'h0;
        for (int i = 0; i < sz; i++) begin
            if (m_a[i] == lk_addr) begin
                e_hit   = 1'b1;
                e_ldata = m_d[i];
            end
        end
        check_val("count",       32'(count),      32'(sz));
        check_val("empty",       32'(empty),      32'(sz == 0));
        check_val("mem_valid",   32'(mem_valid),  32'(sz != 0));
        check_val("mem_addr",    mem_addr,        (sz != 0) ? m_a[0] : 32'h0);
        check_val("mem_data",    mem_data,        (sz != 0) ? m_d[0] : 32'h0);
        check_val("evict_ready", 32'(ev_ready),   32'((sz < DEPTH) && !m_flushing));
        check_val("flush_done",  32'(flush_done), 32'(m_done));
        check_val("lookup_hit",  32'(lk_hit),     32'(e_hit));
        check_val("lookup_data", lk_data,         e_ldata);
    endtask

    task automatic model_update();
        bit push, pop, merged;
        push   = ev_valid && (m_a.size() < DEPTH) && !m_flushing;
        pop    = (m_a.size() != 0) && mem_ready;
        merged = 1'b0;
`ifdef WB_COALESCE_EN
        if (push) begin
            for (int i = m_a.size() - 1; i >= 1; i--) begin
                if (!merged && m_a[i] == ev_addr) begin
                    m_d[i] = ev_data;
                    merged = 1'b1;
                end
            end
        end
`endif
        if (pop) begin
            void'(m_a.pop_front());
            void'(m_d.pop_front());
        end
        if (push && !merged) begin
            m_a.push_back(ev_addr);
            m_d.push_back(ev_data);
        end
        m_done = 1'b0;
        if (m_flushing) begin
            if (m_a.size() == 0) begin
                m_flushing = 1'b0;
                m_done     = 1'b1;
            end
        end else if (flush) begin
            m_flushing = 1'b1;
        end
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        #1;
        cmp_outputs();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ev_valid  = 1'b0;
        ev_addr   = 32'h0;
        ev_data   = 32'h0;
        mem_ready = 1'b0;
        flush     = 1'b0;
        lk_addr   = 32'hFFFF_FFF0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("rst_count",     32'(count),     32'h0);
        check_val("rst_mem_valid", 32'(mem_valid), 32'h0);
        m_a.delete();
        m_d.delete();
        m_flushing = 1'b0;
        m_done     = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] d);
        ev_valid = 1'b1;
        ev_addr  = a;
        ev_data  = d;
        step();
        ev_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m_flushing = 1'b0;
        m_done     = 1'b0;
        #12;
        rst = 1'b0;

        // Reset values and single eviction held stable under backpressure.
        @(negedge clk);
        #1;
        check_val("reset_ready", 32'(ev_ready), 32'h1);
        check_val("reset_empty", 32'(empty),    32'h1);
        push1(32'hAAAA_A028, 32'h1234_5678);
        check_val("t1_count", 32'(count), 32'h1);
        check_val("t1_addr",  mem_addr,   32'hAAAA_A028);
        check_val("t1_data",  mem_data,   32'h1234_5678);
        for (int i = 0; i < 3; i++) step();
        check_val("t1_hold", mem_addr, 32'hAAAA_A028);

        // Fill, reject fifth, drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) push1(32'h100 + 32'(i) * 4, 32'hD0 + 32'(i));
        check_val("t2_full_ready", 32'(ev_ready), 32'h0);
        ev_valid = 1'b1; ev_addr = 32'h200; ev_data = 32'hEE;
        step();
        ev_valid  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("t2_drain_addr", mem_addr, 32'h100 + 32'(i) * 4);
            step();
        end
        check_val("t2_empty", 32'(empty), 32'h1);
        mem_ready = 1'b0;

        // Full queue with simultaneous push and pop.
        for (int i = 0; i < 4; i++) push1(32'h300 + 32'(i) * 4, 32'hA0 + 32'(i));
        ev_valid = 1'b1; ev_addr = 32'h400; ev_data = 32'hB0; mem_ready = 1'b1;
        step();
        check_val("t3_pop_only", 32'(count), 32'h3);
        ev_addr = 32'h404; ev_data = 32'hB1;
        step();
        check_val("t3_push_pop", 32'(count), 32'h3);
        ev_valid = 1'b0; mem_ready = 1'b0;

        // Lookup hit and miss.
        do_reset();
        push1(32'hAAAA_A028, 32'h11);
        push1(32'hBBBB_B028, 32'h22);
        lk_addr = 32'hBBBB_B028;
        #1;
        check_val("t4_hit",  32'(lk_hit), 32'h1);
        check_val("t4_data", lk_data,     32'h22);
        lk_addr = 32'hCCCC_C028;
        #1;
        check_val("t4_miss",      32'(lk_hit), 32'h0);
        check_val("t4_miss_data", lk_data,     32'h0);
        step();

        // Coalescing scenario.
        do_reset();
        push1(32'hA0, 32'h1);
        push1(32'hB0, 32'h2);
        push1(32'hB0, 32'h3);
        lk_addr = 32'hB0;
        #1;
        check_val("t5_lookup", lk_data, 32'h3);
`ifdef WB_COALESCE_EN
        check_val("t5_count_a", 32'(count), 32'h2);
        push1(32'hA0, 32'h4);
        check_val("t5_count_b", 32'(count), 32'h3);
`else
        check_val("t5_count_a", 32'(count), 32'h3);
        push1(32'hA0, 32'h4);
        check_val("t5_count_b", 32'(count), 32'h4);
`endif

        // Flush with entries, then flush when empty, then reset mid-operation.
        do_reset();
        push1(32'h500, 32'h55);
        push1(32'h504, 32'h56);
        flush = 1'b1; mem_ready = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_done) break;
        end
        check_val("t6_done",  32'(flush_done), 32'h1);
        check_val("t6_ready", 32'(ev_ready),   32'h1);
        step();
        check_val("t6_pulse", 32'(flush_done), 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        check_val("t6_empty_flush", 32'(flush_done), 32'h1);
        mem_ready = 1'b0;
        push1(32'h600, 32'h66);
        push1(32'h604, 32'h67);
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            ev_valid  = ($urandom_range(0, 99) < 60);
            ev_addr   = 32'h40 + 32'($urandom_range(0, 5)) * 4;
            ev_data   = $urandom;
            mem_ready = ($urandom_range(0, 99) < 45);
            flush     = ($urandom_range(0, 99) < 4);
            lk_addr   = 32'h40 + 32'($urandom_range(0, 6)) * 4;
            step();
            if (n == 1500) begin
                idle_inputs();
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_evict_buffer.md
# wb_evict_buffer

Write-back eviction buffer sitting directly downstream of the direct-mapped write-back cache. Accepts dirty-line evictions (address + data word) from the cache, holds them in a small in-order queue, and drains them to main memory over a valid/ready handshake. Provides a same-cycle lookup port so a cache miss can forward data still pending in the buffer, and a flush request that blocks new evictions until the queue is empty.

## Interface
- DEPTH, 4, number of eviction entries; power of two, 2..16
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- evict_valid  in  1  cache presents an eviction this cycle
- evict_addr  in  ADDR_W  evicted line address
- evict_data  in  DATA_W  evicted line data
- evict_ready  out  1  buffer accepts an eviction this cycle
- lookup_addr  in  ADDR_W  address of current cache miss
- lookup_hit  out  1  a pending entry matches lookup_addr
- lookup_data  out  DATA_W  data of newest matching entry, 0 if none
- mem_valid  out  1  head entry presented to memory
- mem_addr  out  ADDR_W  head entry address, 0 when empty
- mem_data  out  DATA_W  head entry data, 0 when empty
- mem_ready  in  1  memory accepts head entry
- flush  in  1  one-cycle request to drain the buffer
- flush_done  out  1  one-cycle pulse when a flush completes
- count  out  $clog2(DEPTH+1)  number of occupied entries
- empty  out  1  count == 0

## Operation
- Storage: circular queue, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, separate count register.
- Push: evict_valid && evict_ready at rising edge writes {evict_addr, evict_data} at tail, tail+1, count+1.
- Pop: mem_valid && mem_ready at rising edge advances head, count-1.
- Push and pop same edge: both occur, count unchanged. Full: evict_ready=0 regardless of same-cycle pop.
- evict_ready = (count < DEPTH) && state==IDLE.
- mem_valid = !empty; mem_addr/mem_data from head entry; stable while mem_valid && !mem_ready.
- Lookup: combinational compare of lookup_addr against all occupied entries (head included); newest (closest to tail) match wins. Does not see a push occurring on the same edge.
- FSM, states IDLE and FLUSH:
  - IDLE: flush=1 -> FLUSH.
  - FLUSH: evict_ready=0; draining continues; when count==0 (including count reaching 0 on this edge's pop) -> IDLE with flush_done=1 for exactly one cycle.
  - flush in IDLE with buffer already empty: FLUSH for one cycle, then flush_done pulse.
  - flush asserted while in FLUSH: ignored.
- Reset mid-operation: all entries discarded, no writeback of pending data; state IDLE.

## Timing
- Reset values: evict_ready=1, mem_valid=0, mem_addr=0, mem_data=0, lookup_hit=0, lookup_data=0, flush_done=0, count=0, empty=1.
- Push at edge N: entry visible on count, lookup and (if queue was empty) mem_valid from cycle N+1.
- Pop at edge N: next entry on mem_* from cycle N+1; no bubble between back-to-back pops.
- Minimum latency eviction-to-memory: 1 cycle.
- flush_done asserted in the cycle after the edge on which count became (or was observed) 0 in FLUSH; evict_ready returns to 1 in that same cycle.
- All outputs except lookup_hit/lookup_data are functions of registered state only; lookup_* combinational from lookup_addr.

## Configuration
- WB_COALESCE_EN defined: a push whose evict_addr matches an occupied non-head entry overwrites that entry's data in place; tail and count unchanged; evict_ready still requires count < DEPTH. Head entry never coalesced (it may be mid-handshake); a head match appends a new entry. If several non-head entries match, the newest is overwritten.
- Not defined: every accepted push appends a new entry; duplicates drain in order.

## Test plan
- Reset then push 0xAAAAA028/0x12345678 with mem_ready=0 -> next cycle count=1, mem_valid=1, mem_addr=0xAAAAA028, mem_data=0x12345678; held stable 3 cycles.
- Push 4 entries (DEPTH=4) with mem_ready=0 -> evict_ready=0 after 4th; 5th evict_valid ignored; raise mem_ready -> 4 pops in 4 consecutive cycles in push order, then empty=1.
- Full queue, simultaneous evict_valid and mem_ready -> only pop happens, count 4->3; next cycle push accepted, count stays 3 with simultaneous pop.
- Entries 0xAAAAA028/0x11 then 0xBBBBB028/0x22, lookup_addr=0xBBBBB028 -> lookup_hit=1, lookup_data=0x22; lookup_addr=0xCCCCC028 -> lookup_hit=0, lookup_data=0.
- WB_COALESCE_EN, mem_ready=0: push 0xA0/0x1, 0xB0/0x2, 0xB0/0x3 -> count=2, lookup 0xB0 gives 0x3; push 0xA0/0x4 -> count=3 (head not coalesced). Without macro same stimulus -> count=3 then 4.
- Two entries queued, pulse flush, mem_ready=1 -> evict_ready=0 during drain, flush_done single pulse the cycle after empty, then evict_ready=1; assert reset with entries pending -> count=0, mem_valid=0 immediately.
